// File: rtl/uart_tx_sched.sv
// Transmit scheduler for a UART byte transmitter.
// Round-robin arbitration between two valid/ready byte sources. The granted
// byte is held on tx_data for the whole frame and a send strobe is generated.
// The transmitter busy flag is followed through one frame, with a timeout if
// busy never rises. An idle gap is inserted before the next grant.
module uart_tx_sched #(
    parameter int WRSIG_LEN    = 2,   // strobe length in cycles (1..15)
    parameter int BUSY_TIMEOUT = 16,  // cycles from strobe start to busy (8..255)
    parameter int GAP_CYCLES   = 4    // idle cycles after a frame (0..255)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wrsig,
    output logic        err_timeout,
    output logic [15:0] sent_cnt
);

    typedef enum logic [2:0] {
        ST_ARB,
        ST_STROBE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // Terminal counts; cnt runs from strobe start, so the timeout compares
    // against the same counter that times the strobe.
    localparam logic [7:0] WRSIG_LAST   = 8'(WRSIG_LEN - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_wrsig_q, tx_wrsig_d;
    logic        err_timeout_q, err_timeout_d;
    logic [15:0] sent_cnt_q, sent_cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_seen_q, busy_seen_d;

    logic        eligible;
    logic        sel1;
    logic        grant_any;

    // Arbitration: requester 1 wins if it is the only one valid, or if both
    // are valid and requester 0 was granted last. Readies are masked in reset.
    always_comb begin
        eligible   = enable & ~tx_busy;
        sel1       = req1_valid & (~req0_valid | ~last_grant_q);
        grant_any  = rst_n & (state_q == ST_ARB) & eligible & (req0_valid | req1_valid);
        req0_ready = grant_any & ~sel1;
        req1_ready = grant_any & sel1;
    end

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_wrsig_d    = tx_wrsig_q;
        err_timeout_d = 1'b0;
        sent_cnt_d    = sent_cnt_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        busy_seen_d   = busy_seen_q;
        case (state_q)
            ST_ARB: begin
                if (grant_any) begin
                    tx_data_d    = sel1 ? req1_data : req0_data;
                    last_grant_d = sel1;
                    tx_wrsig_d   = 1'b1;
                    cnt_d        = 8'd0;
                    busy_seen_d  = 1'b0;
                    state_d      = ST_STROBE;
                end
            end
            ST_STROBE: begin
                cnt_d = cnt_q + 8'd1;
                if (tx_busy) begin
                    busy_seen_d = 1'b1;
                end
                if (cnt_q >= WRSIG_LAST) begin
                    tx_wrsig_d = 1'b0;
                    state_d    = (busy_seen_q | tx_busy) ? ST_WAIT_DONE : ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    // Transmitter never started: drop the byte, do not count it.
                    err_timeout_d = 1'b1;
                    cnt_d         = 8'd0;
                    state_d       = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    sent_cnt_d = sent_cnt_q + 16'd1;
                    cnt_d      = 8'd0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_ARB;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ARB;
            tx_data_q     <= 8'd0;
            tx_wrsig_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            sent_cnt_q    <= 16'd0;
            last_grant_q  <= 1'b1;
            cnt_q         <= 8'd0;
            busy_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_wrsig_q    <= tx_wrsig_d;
            err_timeout_q <= err_timeout_d;
            sent_cnt_q    <= sent_cnt_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            busy_seen_q   <= busy_seen_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_wrsig    = tx_wrsig_q;
    assign err_timeout = err_timeout_q;
    assign sent_cnt    = sent_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple transmitter busy model.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = 8'h00;
    logic        req0_ready, req1_ready, tx_wrsig, err_timeout;
    logic [7:0]  tx_data;
    logic [15:0] sent_cnt;
    logic        m_busy = 1'b0;
    logic        ext_busy = 1'b0;
    logic        tx_busy;

    int compared = 0;
    int mismatched = 0;

    assign tx_busy = m_busy | ext_busy;

    always #5 clk = ~clk;

    uart_tx_sched #(.WRSIG_LEN(2), .BUSY_TIMEOUT(16), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_wrsig(tx_wrsig),
        .err_timeout(err_timeout), .sent_cnt(sent_cnt)
    );

    // Transmitter model: busy rises busy_dly cycles after wrsig rises, stays busy_len cycles.
    bit   model_on = 1'b1;
    int   busy_dly = 4;
    int   busy_len = 169;
    int   m_dly = 0;
    int   m_len = 0;
    logic m_wr_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_busy = 1'b0; m_dly = 0; m_len = 0; m_wr_prev = 1'b0;
        end else begin
            if (m_busy) begin
                if (m_len <= 1) m_busy = 1'b0; else m_len--;
            end else if (m_dly != 0) begin
                m_dly--;
                if (m_dly == 0) begin m_busy = 1'b1; m_len = busy_len; end
            end
            if (tx_wrsig && !m_wr_prev && model_on) m_dly = busy_dly;
            m_wr_prev = tx_wrsig;
        end
    end

    // Passive monitor sampled mid-cycle when everything is stable.
    int cyc = 0, r0_cnt = 0, r1_cnt = 0, both_cnt = 0, err_cnt = 0, err_at = -1, err_cyc = 0;
    int wr_run = 0, last_wr_len = 0, wr_start = 0, fall_cyc = 0, last_gap = 0, last_rdy_cyc = 0;
    int hold_viol = 0;
    logic busy_prev = 1'b0, wr_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    int gq[$];
    logic [7:0] dq[$];
    always @(negedge clk) begin
        cyc++;
        if (req0_ready && req1_ready) both_cnt++;
        if (req0_ready || req1_ready) begin last_gap = cyc - fall_cyc; last_rdy_cyc = cyc; end
        if (req0_ready) begin r0_cnt++; gq.push_back(0); dq.push_back(req0_data); end
        if (req1_ready) begin r1_cnt++; gq.push_back(1); dq.push_back(req1_data); end
        if (busy_prev && !tx_busy) fall_cyc = cyc;
        if (tx_wrsig && !wr_prev) wr_start = cyc;
        if (rst_n && (tx_data != data_prev) && !(tx_wrsig && !wr_prev)) hold_viol++;
        if (tx_wrsig) wr_run++;
        else begin
            if (wr_prev) last_wr_len = wr_run;
            wr_run = 0;
        end
        if (err_timeout) begin err_cnt++; err_at = cyc - wr_start; err_cyc = cyc; end
        busy_prev = tx_busy;
        wr_prev   = tx_wrsig;
        data_prev = tx_data;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int lim);
        int n = 0;
        while (!(req0_ready || req1_ready) && n < lim) begin step(); n++; end
        chk({tag, "_ready_seen"}, 32'(req0_ready | req1_ready), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input int lim);
        int n = 0;
        while (!tx_busy && n < lim) begin step(); n++; end
        chk({tag, "_busy_seen"}, 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_sent(input string tag, input logic [15:0] target, input int lim);
        int n = 0;
        while (sent_cnt !== target && n < lim) begin step(); n++; end
        chk({tag, "_sent_cnt"}, 32'(sent_cnt), 32'(target));
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int e0, r0b, r1b;

    // Directed test sequence.
    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_wrsig", 32'(tx_wrsig), 32'd0);
        chk("rst_sent", 32'(sent_cnt), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        req0_valid = 1'b1; req0_data = 8'h5A; enable = 1'b1;
        #1 chk("rst_ready_gated", 32'(req0_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;

        // Single frame from requester 0
        wait_ready("t1", 10);
        chk("t1_sel0", 32'(req0_ready), 32'd1);
        step(); req0_valid = 1'b0;
        wait_busy("t1", 20);
        chk("t1_data_busy", 32'(tx_data), 32'h5A);
        wait_sent("t1", 16'd1, 400);
        chk("t1_r0_once", 32'(r0_cnt), 32'd1);
        chk("t1_wr_len", 32'(last_wr_len), 32'd2);
        chk("t1_data_after", 32'(tx_data), 32'h5A);
        chk("t1_hold", 32'(hold_viol), 32'd0);

        // Both requesters continuously valid: alternate grants
        busy_len = 20;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        gq.delete(); dq.delete();
        req0_data = 8'hA1; req1_data = 8'hB2; req0_valid = 1'b1; req1_valid = 1'b1;
        wait_sent("t2", 16'd4, 1000);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("t2_grants", 32'(gq.size()), 32'd4);
        chk("t2_g0", 32'(gq[0]), 32'd0);
        chk("t2_g1", 32'(gq[1]), 32'd1);
        chk("t2_g2", 32'(gq[2]), 32'd0);
        chk("t2_g3", 32'(gq[3]), 32'd1);
        chk("t2_d0", 32'(dq[0]), 32'hA1);
        chk("t2_d1", 32'(dq[1]), 32'hB2);
        chk("t2_both", 32'(both_cnt), 32'd0);
        chk("t2_gap_min4", 32'(last_gap >= 4), 32'd1);

        // Transmitter never goes busy
        model_on = 1'b0;
        e0 = err_cnt; r1b = r1_cnt;
        req1_data = 8'hC3; req1_valid = 1'b1;
        wait_ready("t3", 20);
        chk("t3_sel1", 32'(req1_ready), 32'd1);
        step(); req1_valid = 1'b0; req0_data = 8'h11; req0_valid = 1'b1;
        begin
            int n = 0;
            while (err_cnt == e0 && n < 40) begin step(); n++; end
        end
        chk("t3_err_seen", 32'(err_cnt - e0), 32'd1);
        chk("t3_err_at", 32'(err_at), 32'd16);
        chk("t3_sent_kept", 32'(sent_cnt), 32'd4);
        wait_ready("t3b", 20);
        chk("t3_next_req0", 32'(req0_ready), 32'd1);
        model_on = 1'b1;
        step(); req0_valid = 1'b0;
        chk("t3_gap", 32'(last_rdy_cyc - err_cyc), 32'd4);
        chk("t3_no_retry", 32'(r1_cnt), 32'(r1b + 1));
        chk("t3_err_once", 32'(err_cnt), 32'(e0 + 1));
        chk("t3_tx_data", 32'(tx_data), 32'h11);
        wait_sent("t3", 16'd5, 100);

        // enable dropped during the frame
        req0_data = 8'h22; req0_valid = 1'b1;
        wait_ready("t4", 20);
        step();
        wait_busy("t4", 20);
        enable = 1'b0; r0b = r0_cnt;
        wait_sent("t4", 16'd6, 100);
        repeat (20) step();
        chk("t4_no_ready_cnt", 32'(r0_cnt), 32'(r0b));
        chk("t4_no_ready_now", 32'(req0_ready), 32'd0);
        enable = 1'b1;
        #1 chk("t4_reenable", 32'(req0_ready), 32'd1);
        step(); req0_valid = 1'b0;
        wait_sent("t4b", 16'd7, 100);

        // External holder keeps busy high during arbitration
        ext_busy = 1'b1; r1b = r1_cnt;
        req1_data = 8'h33; req1_valid = 1'b1;
        repeat (15) step();
        chk("t5_blocked", 32'(r1_cnt), 32'(r1b));
        ext_busy = 1'b0;
        #1 chk("t5_grant", 32'(req1_ready), 32'd1);
        step(); req1_valid = 1'b0;
        chk("t5_data", 32'(tx_data), 32'h33);
        wait_sent("t5", 16'd8, 100);

        // Asynchronous reset in the middle of a frame
        req0_data = 8'h44; req0_valid = 1'b1;
        wait_ready("t6", 20);
        step();
        wait_busy("t6", 20);
        repeat (3) step();
        req1_data = 8'h55; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", 32'(tx_data), 32'h00);
        chk("t6_rst_wrsig", 32'(tx_wrsig), 32'd0);
        chk("t6_rst_sent", 32'(sent_cnt), 32'd0);
        chk("t6_rst_err", 32'(err_timeout), 32'd0);
        chk("t6_rst_ready", 32'(req0_ready | req1_ready), 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("t6_prio_req0", 32'(req0_ready), 32'd1);
        chk("t6_prio_not1", 32'(req1_ready), 32'd0);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t6_data", 32'(tx_data), 32'h44);
        wait_sent("t6", 16'd1, 100);

        // Counter wrap
        force dut.sent_cnt_q = 16'hFFFF;
        step();
        release dut.sent_cnt_q;
        step();
        chk("t7_preload", 32'(sent_cnt), 32'hFFFF);
        req0_data = 8'h66; req0_valid = 1'b1;
        wait_ready("t7", 20);
        step(); req0_valid = 1'b0;
        wait_sent("t7_wrap", 16'h0000, 100);
        chk("t7_data", 32'(tx_data), 32'h66);

        chk("hold_global", 32'(hold_viol), 32'd0);
        chk("both_global", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Transmit scheduler sitting in front of the UART byte transmitter.
- Arbitrates round-robin between two byte-producing requesters, each with a valid/ready handshake (e.g. FIFO read side, status reporter).
- Holds the granted byte on tx_data for the whole frame, generates the wrsig strobe, and tracks the transmitter's busy flag through one frame.
- Enforces an inter-frame gap and flags a transmitter that never goes busy.

Parameters:
- WRSIG_LEN, 2: cycles tx_wrsig is held high per byte (1..15).
- BUSY_TIMEOUT, 16: cycles allowed from strobe start until tx_busy must be seen high (8..255).
- GAP_CYCLES, 4: idle cycles inserted after tx_busy falls before the next grant (0..255).

Ports:
- clk  in  1  single clock, shared with transmitter.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = new grants allowed; 0 = finish the current byte, then hold in ARB.
- req0_valid  in  1  requester 0 has a byte; held until accepted.
- req0_data  in  8  requester 0 byte, stable while valid.
- req0_ready  out  1  combinational accept strobe for requester 0.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  accept strobe for requester 1.
- tx_busy  in  1  transmitter line status, 1 = frame in progress.
- tx_data  out  8  registered byte to transmitter, stable for the whole frame.
- tx_wrsig  out  1  registered send strobe; transmitter acts on its rising edge.
- err_timeout  out  1  one-cycle pulse when BUSY_TIMEOUT expires.
- sent_cnt  out  16  frames completed; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, rst_n=0):
  - state=ARB, tx_data=0, tx_wrsig=0, err_timeout=0, sent_cnt=0, last_grant=1 (so requester 0 wins first), counters=0.
  - Ready outputs are 0 while in reset.
  - Reset mid-frame abandons the byte; no further strobe is issued.
- States: ARB, STROBE, WAIT_BUSY, WAIT_DONE, GAP.
- ARB:
  - eligible = enable & ~tx_busy.
  - If eligible and exactly one valid, that requester is selected. If both are valid, select the requester other than last_grant.
  - reqN_ready = (state==ARB) & eligible & selected==N. The handshake completes in that cycle.
  - At the clock edge: tx_data<=reqN_data, last_grant<=N, tx_wrsig<=1, cnt<=0, go to STROBE.
  - With no valid requester, stay in ARB with tx_data unchanged.
- STROBE:
  - Hold tx_wrsig=1 for exactly WRSIG_LEN cycles, counting the cycle after ARB as 1.
  - Then tx_wrsig<=0 and go to WAIT_BUSY. cnt keeps counting from strobe start.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise, when cnt reaches BUSY_TIMEOUT-1 without busy: err_timeout=1 for one cycle, go to GAP. The byte is dropped and sent_cnt is unchanged.
  - tx_busy seen high already during STROBE also satisfies the check; go to WAIT_DONE at the end of STROBE.
- WAIT_DONE:
  - Wait for tx_busy=0 with no upper bound; tx_data is held.
  - On the falling edge of busy: sent_cnt<=sent_cnt+1, cnt<=0, go to GAP.
- GAP: wait GAP_CYCLES cycles (0 means return next cycle), then go to ARB.
- Ready is never asserted outside ARB. Only one ready is high in any cycle.
- Deasserting enable outside ARB has no effect on the frame in flight.
- Latency, idle to line: ready-cycle edge -> tx_wrsig high next cycle. The transmitter start bit follows about 3 cycles later.
- Throughput limit: one byte per frame + GAP_CYCLES + arbitration cycle.

Test Plan:
- Reset, then req0_valid=1, data=0x5A, tx_busy model goes high 4 cycles after wrsig rises and stays high 169 cycles:
  - req0_ready pulses once.
  - tx_data=0x5A held until busy falls.
  - tx_wrsig high exactly 2 cycles.
  - sent_cnt=1.
- Both requesters valid continuously (0xA1 on req0, 0xB2 on req1):
  - Grants alternate 0,1,0,1.
  - 4 frames give sent_cnt=4.
  - No cycle has both readies high.
  - At least 4 cycles between busy falling and the next ready.
- Transmitter never raises busy:
  - err_timeout pulses exactly at cycle 16 after strobe start.
  - sent_cnt is unchanged.
  - The next grant follows GAP.
  - The dropped byte is not retried.
- enable dropped during WAIT_DONE:
  - The current frame completes and sent_cnt increments.
  - No further ready while enable=0.
  - Re-enable gives a grant in the next ARB cycle.
- tx_busy already high in ARB (external holder): no ready until busy=0, then grant in the next cycle.
- Assert rst_n=0 in the middle of WAIT_DONE:
  - All outputs go to reset values immediately (async).
  - After release, requester 0 has priority.
- Preload sent_cnt to 0xFFFF via 65535 frames or a force, then complete one frame: sent_cnt wraps to 0x0000.
